// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency data-memory port between the core and the loader.
// Build macro ARB_ADDR_CHECK_EN: out-of-range or misaligned requests are answered with an error and never reach memory.
module dmem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int MEM_BYTES   = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                c_req_valid,
   output logic                c_req_ready,
   input  logic                c_req_we,
   input  logic [ADDR_W-1:0]   c_req_addr,
   input  logic [DATA_W-1:0]   c_req_wdata,
   input  logic [DATA_W/8-1:0] c_req_wstrb,
   output logic                c_resp_valid,
   output logic [DATA_W-1:0]   c_resp_rdata,
   output logic                c_resp_err,
   input  logic                l_req_valid,
   output logic                l_req_ready,
   input  logic                l_req_we,
   input  logic [ADDR_W-1:0]   l_req_addr,
   input  logic [DATA_W-1:0]   l_req_wdata,
   input  logic [DATA_W/8-1:0] l_req_wstrb,
   output logic                l_resp_valid,
   output logic [DATA_W-1:0]   l_resp_rdata,
   output logic                l_resp_err,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata
);
   localparam int STRB_W = DATA_W / 8;

   // state | meaning
   // IDLE  | arbitrate and accept at most one request
   // ISSUE | one-cycle memory strobe with the latched request
   // WAIT  | count down memory latency, then capture read data
   // RESP  | one-cycle response to the granted requester
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state, state_nxt;
   logic                last_grant;  // 1 = loader
   logic                grant;       // 1 = loader
   logic                pick_l, pick_c, hs, addr_bad;
   logic                req_we;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic [STRB_W-1:0]   req_wstrb;
   logic [DATA_W-1:0]   rdata_q;
   logic [3:0]          cnt;

   assign pick_l = l_req_valid && (!c_req_valid || !last_grant);
   assign pick_c = c_req_valid && !pick_l;
   assign hs     = (state == IDLE) && !reset && (c_req_valid || l_req_valid);

`ifdef ARB_ADDR_CHECK_EN
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);
   logic              err_q;
   logic [ADDR_W-1:0] hs_addr;

   assign hs_addr  = pick_l ? l_req_addr : c_req_addr;
   assign addr_bad = (hs_addr >= ADDR_W'(MEM_BYTES)) || ((hs_addr & ALIGN_MASK) != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      err_q <= 1'b0;
      else if (hs)                    err_q <= addr_bad;
   end

   assign c_resp_err = c_resp_valid & err_q;
   assign l_resp_err = l_resp_valid & err_q;
`else
   assign addr_bad   = 1'b0;
   assign c_resp_err = 1'b0;
   assign l_resp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      c_req_ready  = 1'b0;
      l_req_ready  = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wstrb    = '0;
      c_resp_valid = 1'b0;
      l_resp_valid = 1'b0;
      c_resp_rdata = '0;
      l_resp_rdata = '0;
      case (state)
         IDLE: begin
            c_req_ready = pick_c && !reset;
            l_req_ready = pick_l && !reset;
            if (hs) state_nxt = addr_bad ? RESP : ISSUE;
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = req_we;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
            mem_wstrb = req_wstrb;
            state_nxt = WAIT;
         end
         WAIT: if (cnt == 4'd0) state_nxt = RESP;
         RESP: begin
            if (grant) begin
               l_resp_valid = 1'b1;
               l_resp_rdata = rdata_q;
            end else begin
               c_resp_valid = 1'b1;
               c_resp_rdata = rdata_q;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         grant      <= 1'b0;
         req_we     <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         req_wstrb  <= '0;
         rdata_q    <= '0;
         cnt        <= 4'd0;
      end else begin
         case (state)
            IDLE: if (hs) begin
               grant      <= pick_l;
               last_grant <= pick_l;
               req_we     <= pick_l ? l_req_we    : c_req_we;
               req_addr   <= pick_l ? l_req_addr  : c_req_addr;
               req_wdata  <= pick_l ? l_req_wdata : c_req_wdata;
               req_wstrb  <= pick_l ? l_req_wstrb : c_req_wstrb;
               rdata_q    <= '0;
            end
            ISSUE: cnt <= 4'(MEM_LATENCY - 1);
            WAIT: begin
               // stores answer with zero data regardless of what the memory returns
               if (cnt == 4'd0) rdata_q <= req_we ? '0 : mem_rdata;
               else             cnt     <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a transaction-level timing and memory model.
// Honours ARB_ADDR_CHECK_EN the same way as the design build.
module tb_dmem_port_arbiter;
   localparam int LAT       = 4;
   localparam int MEM_BYTES = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c_req_valid, c_req_ready, c_req_we;
   logic [31:0] c_req_addr, c_req_wdata;
   logic [3:0]  c_req_wstrb;
   logic        c_resp_valid, c_resp_err;
   logic [31:0] c_resp_rdata;
   logic        l_req_valid, l_req_ready, l_req_we;
   logic [31:0] l_req_addr, l_req_wdata;
   logic [3:0]  l_req_wstrb;
   logic        l_resp_valid, l_resp_err;
   logic [31:0] l_resp_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   dmem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .MEM_BYTES(MEM_BYTES)
   ) u_dut (
      .clk(clk), .reset(reset),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
      .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_req_wstrb(c_req_wstrb),
      .c_resp_valid(c_resp_valid), .c_resp_rdata(c_resp_rdata), .c_resp_err(c_resp_err),
      .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
      .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata), .l_req_wstrb(l_req_wstrb),
      .l_resp_valid(l_resp_valid), .l_resp_rdata(l_resp_rdata), .l_resp_err(l_resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0, n_bad = 0;
   int          cyc, issue_cyc, resp_cyc, busy_end, rd_cyc;
   bit          last_l, own_l, t_we, t_err, hs_c, hs_l, hold_mode;
   logic [31:0] t_addr, t_wdata, t_rdata, rd_data;
   logic [3:0]  t_wstrb;
   logic [31:0] dev_mem [2048];
   logic [31:0] ref_mem [2048];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic bit addr_bad(input logic [31:0] a);
`ifdef ARB_ADDR_CHECK_EN
      return (a >= 32'(MEM_BYTES)) || (a[1:0] != 2'b00);
`else
      return (a === 32'hx);
`endif
   endfunction

   task automatic new_req(output logic we, output logic [31:0] addr, output logic [31:0] wdata,
                          output logic [3:0] strb);
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
         0:       addr = 32'h0000_1000;
         1:       addr = 32'h0000_0FFC;
         2:       addr = 32'h0000_0012;
         3:       addr = 32'hFFFF_FFF0;
         default: addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      endcase
      wdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
   endtask

   // Expected behaviour per cycle: an accepted request owns the port for LAT+2 more cycles
   // (1 for a rejected address); memory strobe in the next cycle, response in the last.
   task automatic monitor();
      bit idle, ecr, elr;
      idle = (cyc > busy_end);
      ecr  = idle && c_req_valid && (!l_req_valid || last_l);
      elr  = idle && l_req_valid && (!c_req_valid || !last_l);
      check("c_req_ready", 32'(c_req_ready), 32'(ecr));
      check("l_req_ready", 32'(l_req_ready), 32'(elr));
      check("mem_en", 32'(mem_en), 32'(cyc == issue_cyc));
      if (cyc == issue_cyc) begin
         check("mem_we", 32'(mem_we), 32'(t_we));
         check("mem_addr", mem_addr, t_addr);
         check("mem_wdata", mem_wdata, t_wdata);
         check("mem_wstrb", 32'(mem_wstrb), 32'(t_wstrb));
      end else begin
         check("mem_fields_idle", {31'd0, mem_we | (|mem_addr) | (|mem_wdata) | (|mem_wstrb)}, 32'd0);
      end
      check("c_resp_valid", 32'(c_resp_valid), 32'(cyc == resp_cyc && !own_l));
      check("l_resp_valid", 32'(l_resp_valid), 32'(cyc == resp_cyc && own_l));
      if (cyc == resp_cyc) begin
         if (own_l) begin
            check("l_resp_rdata", l_resp_rdata, t_rdata);
            check("l_resp_err", 32'(l_resp_err), 32'(t_err));
         end else begin
            check("c_resp_rdata", c_resp_rdata, t_rdata);
            check("c_resp_err", 32'(c_resp_err), 32'(t_err));
         end
      end
      if (mem_en) begin
         if (mem_we) dev_mem[mem_addr[12:2]] = merge(dev_mem[mem_addr[12:2]], mem_wdata, mem_wstrb);
         else begin
            rd_cyc  = cyc + LAT;
            rd_data = dev_mem[mem_addr[12:2]];
         end
      end
      if (ecr || elr) begin
         own_l   = elr;
         last_l  = elr;
         t_we    = elr ? l_req_we    : c_req_we;
         t_addr  = elr ? l_req_addr  : c_req_addr;
         t_wdata = elr ? l_req_wdata : c_req_wdata;
         t_wstrb = elr ? l_req_wstrb : c_req_wstrb;
         t_err   = addr_bad(t_addr);
         t_rdata = 32'd0;
         if (t_err) begin
            issue_cyc = -1;
            resp_cyc  = cyc + 1;
         end else begin
            issue_cyc = cyc + 1;
            resp_cyc  = cyc + LAT + 2;
            if (t_we) ref_mem[t_addr[12:2]] = merge(ref_mem[t_addr[12:2]], t_wdata, t_wstrb);
            else      t_rdata = ref_mem[t_addr[12:2]];
         end
         busy_end = resp_cyc;
      end
      hs_c = c_req_valid && c_req_ready;
      hs_l = l_req_valid && l_req_ready;
   endtask

   task automatic drive();
      if (hs_c || !c_req_valid) begin
         if (hold_mode || $urandom_range(0, 2) != 0) begin
            c_req_valid = 1'b1;
            new_req(c_req_we, c_req_addr, c_req_wdata, c_req_wstrb);
         end else c_req_valid = 1'b0;
      end else if (!hold_mode && $urandom_range(0, 15) == 0) c_req_valid = 1'b0;
      if (hs_l || !l_req_valid) begin
         if (hold_mode || $urandom_range(0, 2) != 0) begin
            l_req_valid = 1'b1;
            new_req(l_req_we, l_req_addr, l_req_wdata, l_req_wstrb);
         end else l_req_valid = 1'b0;
      end else if (!hold_mode && $urandom_range(0, 15) == 0) l_req_valid = 1'b0;
      // Read data is only meaningful in the single cycle LAT after the strobe.
      mem_rdata = (cyc == rd_cyc) ? rd_data : $urandom;
      hs_c = 1'b0;
      hs_l = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      drive();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      check({tag, "_ready"}, 32'({c_req_ready, l_req_ready}), 32'd0);
      check({tag, "_resp"}, 32'({c_resp_valid, l_resp_valid, c_resp_err, l_resp_err}), 32'd0);
      check({tag, "_rdata"}, c_resp_rdata | l_resp_rdata, 32'd0);
      check({tag, "_mem_fields"}, {31'd0, mem_we | (|mem_addr) | (|mem_wdata) | (|mem_wstrb)}, 32'd0);
   endtask

   task automatic reset_in_wait();
      int guard = 0;
      while (!(issue_cyc >= 0 && cyc > issue_cyc && cyc < resp_cyc) && guard < 200) begin
         step();
         guard++;
      end
      check("wait_state_reached", 32'(guard < 200), 32'd1);
      reset = 1'b1;
      #1;
      check_all_zero("rst_wait");
      @(posedge clk);
      cyc++;
      #1;
      reset     = 1'b0;
      issue_cyc = -1;
      resp_cyc  = -1;
      busy_end  = -1;
      rd_cyc    = -1;
      last_l    = 1'b1;
      hs_c      = 1'b0;
      hs_l      = 1'b0;
      drive();
   endtask

   initial begin
      cyc = 0; issue_cyc = -1; resp_cyc = -1; busy_end = -1; rd_cyc = -1;
      last_l = 1'b1; own_l = 1'b0; hs_c = 1'b0; hs_l = 1'b0; hold_mode = 1'b1;
      t_we = 1'b0; t_err = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0; t_wstrb = '0; rd_data = '0;
      c_req_valid = 1'b0; c_req_we = 1'b0; c_req_addr = '0; c_req_wdata = '0; c_req_wstrb = '0;
      l_req_valid = 1'b0; l_req_we = 1'b0; l_req_addr = '0; l_req_wdata = '0; l_req_wstrb = '0;
      mem_rdata = '0;
      for (int i = 0; i < 2048; i++) begin
         dev_mem[i] = 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0123);
         ref_mem[i] = dev_mem[i];
      end
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_idle");
      c_req_valid = 1'b1;
      l_req_valid = 1'b1;
      new_req(c_req_we, c_req_addr, c_req_wdata, c_req_wstrb);
      new_req(l_req_we, l_req_addr, l_req_wdata, l_req_wstrb);
      #1;
      check_all_zero("reset_held_valid");
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) step();
      hold_mode = 1'b0;
      repeat (1500) step();
      reset_in_wait();
      repeat (300) step();
      reset_in_wait();
      repeat (300) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
